// File: rtl/sa_ram_fifo_ctrl_60x84_pkg.sv
// Shared constants and pointer helper for the 60x84 RAM-backed FIFO controller.
package sa_ram_fifo_ctrl_60x84_pkg;
  localparam int DEPTH      = 60;
  localparam int WIDTH      = 84;
  localparam int AW         = 6;
  localparam int OBUF_DEPTH = 3;
  localparam int OBUF_CW    = 2;
  localparam int OCC_W      = 7;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [AW-1:0]    ptr_t;

  // DEPTH is not a power of two, so pointers wrap explicitly.
  function automatic ptr_t ptr_wrap(input ptr_t ptr);
    return (ptr == ptr_t'(DEPTH - 1)) ? '0 : ptr + ptr_t'(1);
  endfunction
endpackage

// File: rtl/sa_ram_fifo_ctrl_60x84_obuf.sv
// Small shift-register output FIFO; head is always entry 0, no bypass path.
module sa_fifo_obuf
  import sa_ram_fifo_ctrl_60x84_pkg::*;
#(
  parameter int NUM_ENT = OBUF_DEPTH,
  parameter int CW      = OBUF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  data_t         din,
  input  logic          pop,
  output data_t         dout,
  output logic [CW-1:0] cnt
);
  data_t [NUM_ENT-1:0] mem_q, mem_d;
  logic  [CW-1:0]      cnt_q, cnt_d, wr_idx;

  always_comb begin
    mem_d  = mem_q;
    wr_idx = cnt_q - CW'(pop);
    if (pop)
      for (int i = 0; i < NUM_ENT - 1; i++) mem_d[i] = mem_q[i+1];
    // Tail write lands after the shift so push+pop keeps order.
    if (push)
      for (int i = 0; i < NUM_ENT; i++)
        if (wr_idx == CW'(i)) mem_d[i] = din;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = mem_q[0];
  assign cnt  = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == CW'(NUM_ENT)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && cnt_q == '0));
endmodule

// File: rtl/sa_ram_fifo_ctrl_60x84.sv
// valid/ready FIFO controller around a 2-port RAM with 2-cycle read latency.
module sa_ram_fifo_ctrl_60x84
  import sa_ram_fifo_ctrl_60x84_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [OCC_W-1:0] occ,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  input  logic [31:0]      pwrbus_ram_pd_in,
  output logic [31:0]      ram_pwrbus_ram_pd
);
  ptr_t               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      ram_cnt_q, ram_cnt_d;
  logic [2:1]         vld_pipe_q, vld_pipe_d;
  logic [OBUF_CW-1:0] obuf_cnt;
  logic [2:0]         credit_used;
  logic               push, pop, issue;

  assign wr_prdy = (ram_cnt_q != AW'(DEPTH));
  assign push    = wr_pvld & wr_prdy & ~rst;
  assign rd_pvld = (obuf_cnt != '0);
  assign pop     = rd_pvld & rd_prdy;

  // Reads in flight plus buffered words must leave room for the new one.
  assign credit_used = 3'(vld_pipe_q[1]) + 3'(vld_pipe_q[2]) + 3'(obuf_cnt) - 3'(pop);
  assign issue       = (ram_cnt_q != '0) && (credit_used < 3'(OBUF_DEPTH));

  always_comb begin
    wr_ptr_d   = push  ? ptr_wrap(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = issue ? ptr_wrap(rd_ptr_q) : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q + AW'(push) - AW'(issue);
    vld_pipe_d = {vld_pipe_q[1], issue};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign ram_we  = push;
  assign ram_wa  = wr_ptr_q;
  assign ram_di  = wr_pd;
  assign ram_re  = issue;
  assign ram_ra  = rd_ptr_q;
  assign ram_ore = vld_pipe_q[1];

  assign ram_byp_sel       = 1'b0;
  assign ram_dbyp          = '0;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd_in;

  assign occ = OCC_W'(ram_cnt_q) + OCC_W'(vld_pipe_q[1]) + OCC_W'(vld_pipe_q[2])
             + OCC_W'(obuf_cnt);

  sa_fifo_obuf u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (vld_pipe_q[2]),
    .din  (ram_dout),
    .pop  (pop),
    .dout (rd_pd),
    .cnt  (obuf_cnt)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(ram_we && ram_cnt_q == AW'(DEPTH)));
  a_no_re_empty: assert property (@(posedge clk) disable iff (rst)
    !(ram_re && ram_cnt_q == '0));
endmodule
